// File: rtl/binary_stream_packer.sv
// ---------------------------------------------------------------------------
// binary_stream_packer
//
// Receiving end of the binary skin-mask stream. Tracks frame/line position of
// the 1-bit-per-pixel stream, packs pixels into 16-bit words (first pixel in
// bit 0) and hands them to the frame-buffer writer through a small show-ahead
// FIFO with a valid/ready handshake. The upstream stream cannot be stalled, so
// a word completed while the FIFO is full (and not popping) is dropped and a
// sticky overflow flag is raised.
//
// Optional feature macro: BIN_PACK_FG_COUNT_EN
//   defined   : foreground pixels of each completed frame are counted and
//               presented on oFG_Count.
//   undefined : no counter, oFG_Count is tied to 0.
//
// Parameters
//   LINE_W     pixels per line (multiple of 16)
//   FRAME_H    lines per frame
//   FIFO_DEPTH output FIFO entries (power of 2, >= 2)
//
// Ports
//   iCLK        clock
//   iRST        synchronous active-high reset
//   iBinary     pixel value (1 = skin / foreground)
//   iDVAL       iBinary valid this cycle
//   iFrame_En   capture enable (level)
//   oDATA       FIFO head: packed word
//   oSOF        FIFO head: first word of a frame
//   oEOL        FIFO head: last word of a line
//   oVALID      FIFO head is valid
//   iREADY      consumer accepts head (pop = oVALID & iREADY)
//   oFrame_Done one-cycle pulse when the last pixel of a frame was taken
//   oOverflow   sticky: a completed word was dropped
//   oFG_Count   foreground count of the last completed frame
// ---------------------------------------------------------------------------
module binary_stream_packer #(
  parameter int LINE_W     = 640,
  parameter int FRAME_H    = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBinary,
  input  logic        iDVAL,
  input  logic        iFrame_En,
  output logic [15:0] oDATA,
  output logic        oSOF,
  output logic        oEOL,
  output logic        oVALID,
  input  logic        iREADY,
  output logic        oFrame_Done,
  output logic        oOverflow,
  output logic [19:0] oFG_Count
);

  localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XW-1:0] X_LAST  = XW'(LINE_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_H - 1);
  localparam logic [XW-1:0] X_SOF   = XW'(15);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_WAIT_LOW
  } state_e;

  // -------------------------------------------------------------------------
  // Capture FSM, position counters and word assembly
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [15:0]     shift_q, shift_d;
  logic            frame_done_q, frame_done_d;

  logic            push;
  logic [15:0]     push_word;
  logic            push_sof;
  logic            push_eol;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    x_d          = x_q;
    y_d          = y_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_word    = '0;
    push_sof     = 1'b0;
    push_eol     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iFrame_En) begin
          state_d   = ST_CAPTURE;
          bit_idx_d = '0;
          x_d       = '0;
          y_d       = '0;
          shift_d   = '0;
        end
      end

      ST_CAPTURE: begin
        if (!iFrame_En) begin
          // Abort: partial word and position are discarded; queued words
          // still drain on their own.
          state_d   = ST_IDLE;
          bit_idx_d = '0;
          x_d       = '0;
          y_d       = '0;
          shift_d   = '0;
        end else if (iDVAL) begin
          shift_d[bit_idx_q] = iBinary;
          bit_idx_d          = bit_idx_q + 4'd1;

          if (bit_idx_q == 4'd15) begin
            // shift_d already holds the 16th pixel, so it is the whole word.
            push      = 1'b1;
            push_word = shift_d;
            push_sof  = (x_q == X_SOF) && (y_q == '0);
            push_eol  = (x_q == X_LAST);
          end

          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              state_d      = ST_WAIT_LOW;
              frame_done_d = 1'b1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end

      ST_WAIT_LOW: begin
        // Hold here until the enable drops so one enable yields one frame.
        if (!iFrame_En) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      x_q          <= x_d;
      y_q          <= y_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign oFrame_Done = frame_done_q;

  // -------------------------------------------------------------------------
  // Show-ahead FIFO: {eol, sof, data}
  // -------------------------------------------------------------------------
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [17:0]   head;

  assign full    = (count_q == CNT_MAX);
  assign pop     = oVALID && iREADY;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Dropped word: counters upstream keep advancing, only the flag records it.
    if (push && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which
  // entries are live, and the outputs are masked while the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_eol, push_sof, push_word};
  end

  assign head      = mem_q[rd_ptr_q];
  assign oVALID    = (count_q != '0);
  assign oDATA     = oVALID ? head[15:0] : 16'h0000;
  assign oSOF      = oVALID && head[16];
  assign oEOL      = oVALID && head[17];
  assign oOverflow = overflow_q;

  // -------------------------------------------------------------------------
  // Optional foreground pixel counter
  // -------------------------------------------------------------------------
`ifdef BIN_PACK_FG_COUNT_EN
  logic [19:0] fg_cnt_q, fg_cnt_d;
  logic [19:0] fg_out_q, fg_out_d;
  logic        fg_clr;
  logic        fg_inc;

  always_comb begin
    fg_clr   = ((state_q == ST_IDLE) && iFrame_En) ||
               ((state_q == ST_CAPTURE) && !iFrame_En);
    fg_inc   = (state_q == ST_CAPTURE) && iFrame_En && iDVAL && iBinary;
    fg_cnt_d = fg_cnt_q;
    fg_out_d = fg_out_q;

    if (fg_clr)      fg_cnt_d = '0;
    else if (fg_inc) fg_cnt_d = fg_cnt_q + 20'd1;

    // The final pixel of the frame is counted in the same edge it publishes.
    if (frame_done_d) fg_out_d = fg_cnt_d;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fg_cnt_q <= '0;
      fg_out_q <= '0;
    end else begin
      fg_cnt_q <= fg_cnt_d;
      fg_out_q <= fg_out_d;
    end
  end

  assign oFG_Count = fg_out_q;
`else
  assign oFG_Count = 20'd0;
`endif

endmodule
